// File: rtl/fir_xifu_ctrl.sv
// ----------------------------------------------------------------------------
// fir_xifu_ctrl
//
// In-order instruction tracker and sequencer for the FIR XIFU coprocessor.
// Each instruction accepted by decode is recorded in a circular table.
// CV-X-IF commit/kill messages are matched against the in-flight entries.
// Only the head entry is released: to execute if it was committed, or to
// drop if it was killed.
//
// Ports
//   clk_i, rst_i         clock, synchronous active-high reset
//   clear_i              synchronous flush of all tracked instructions
//   issue_i/issue_id_i   instruction accepted by decode, and its ID
//   issue_ready_o        table not full (decode-stage ready)
//   commit_valid_i       commit message valid
//   commit_id_i          ID being committed or killed
//   commit_kill_i        1 = kill, 0 = commit
//   exec_valid_o         head is committed and may execute
//   exec_id_o            ID of the committed head
//   ex_done_i            execute finished the head instruction
//   drop_o/drop_id_o     head was killed and retires this cycle
//   clear_o              one-cycle flush pulse to the ID/EX register
//   busy_o, count_o      in-flight status and occupancy
// ----------------------------------------------------------------------------
module fir_xifu_ctrl #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ID_WIDTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         clear_i,
  input  logic                         issue_i,
  input  logic [ID_WIDTH-1:0]          issue_id_i,
  output logic                         issue_ready_o,
  input  logic                         commit_valid_i,
  input  logic [ID_WIDTH-1:0]          commit_id_i,
  input  logic                         commit_kill_i,
  output logic                         exec_valid_o,
  output logic [ID_WIDTH-1:0]          exec_id_o,
  input  logic                         ex_done_i,
  output logic                         drop_o,
  output logic [ID_WIDTH-1:0]          drop_id_o,
  output logic                         clear_o,
  output logic                         busy_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  // ST_FREE marks an empty slot, so no separate valid bit is needed.
  typedef enum logic [1:0] {
    ST_FREE      = 2'd0,
    ST_PENDING   = 2'd1,
    ST_COMMITTED = 2'd2,
    ST_KILLED    = 2'd3
  } entry_st_e;

  entry_st_e             st_q [DEPTH];
  entry_st_e             st_d [DEPTH];
  logic [ID_WIDTH-1:0]   id_q [DEPTH];
  logic [ID_WIDTH-1:0]   id_d [DEPTH];
  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  clear_q, clear_d;

  logic                  push;
  logic                  pop;
  entry_st_e             head_st;
  entry_st_e             new_st;

  assign head_st       = st_q[head_q];
  assign issue_ready_o = (count_q != CNT_W'(DEPTH));
  assign push          = issue_i && issue_ready_o;
  assign exec_valid_o  = (head_st == ST_COMMITTED);
  assign drop_o        = (head_st == ST_KILLED);
  // A killed head retires unconditionally; a committed head waits for execute.
  assign pop           = drop_o || (exec_valid_o && ex_done_i);

  // IDs are gated so the outputs read 0 while nothing is presented.
  assign exec_id_o     = exec_valid_o ? id_q[head_q] : '0;
  assign drop_id_o     = drop_o       ? id_q[head_q] : '0;
  assign clear_o       = clear_q;
  assign busy_o        = (count_q != '0);
  assign count_o       = count_q;

  // A commit arriving with its own issue lands directly in the new entry.
  always_comb begin
    new_st = ST_PENDING;
    if (commit_valid_i && (commit_id_i == issue_id_i)) begin
      new_st = commit_kill_i ? ST_KILLED : ST_COMMITTED;
    end
  end

  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    st_d    = st_q;
    id_d    = id_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    clear_d = 1'b0;

    // Only PENDING entries accept a decision, so the first commit/kill wins
    // and free slots never match.
    if (commit_valid_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (st_q[i] == ST_PENDING && id_q[i] == commit_id_i) begin
          st_d[i] = commit_kill_i ? ST_KILLED : ST_COMMITTED;
        end
      end
    end

    if (pop) begin
      st_d[head_q] = ST_FREE;
      head_d       = head_q + PTR_W'(1);
    end

    // The tail slot is always free when push is allowed, so it cannot
    // collide with the commit match or the pop above.
    if (push) begin
      id_d[tail_q] = issue_id_i;
      st_d[tail_q] = new_st;
      tail_d       = tail_q + PTR_W'(1);
    end

    if (clear_i) begin
      for (int i = 0; i < DEPTH; i++) st_d[i] = ST_FREE;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      clear_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) st_q[i] <= ST_FREE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      clear_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      clear_q <= clear_d;
    end
  end

  // NOTE: the ID storage is deliberately not reset; a slot's ID is only ever
  // read while its state is not FREE, and the state array is reset.
  always_ff @(posedge clk_i) begin
    id_q <= id_d;
  end

endmodule

// File: doc/fir_xifu_ctrl.md
# fir_xifu_ctrl

In-order instruction tracker and sequencer for the FIR XIFU coprocessor. Records every instruction accepted by the decode stage, matches CV-X-IF commit and kill messages against the in-flight entries, and releases only committed instructions to the execute stage in issue order. It drives the decode stage's ready, and tells the execute stage to discard killed instructions.

## Interface
- DEPTH, 4: maximum number of in-flight instructions; power of two, at least 2.
- ID_WIDTH, 4: width of the CV-X-IF instruction ID.

- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- clear_i  in  1  synchronous flush of all tracked instructions.
- issue_i  in  1  decode stage accepted an instruction this cycle (id2ctrl.issue).
- issue_id_i  in  ID_WIDTH  ID of the issued instruction (id2ctrl.id).
- issue_ready_o  out  1  tracker can accept an issue; drives the decode stage ready.
- commit_valid_i  in  1  core commit message valid.
- commit_id_i  in  ID_WIDTH  ID being committed or killed.
- commit_kill_i  in  1  1 = kill, 0 = commit.
- exec_valid_o  out  1  head instruction is committed and may execute.
- exec_id_o  out  ID_WIDTH  ID of the head instruction.
- ex_done_i  in  1  execute stage finished the head instruction.
- drop_o  out  1  head instruction was killed and is retired without execution this cycle.
- drop_id_o  out  ID_WIDTH  ID being dropped.
- clear_o  out  1  one-cycle flush pulse to the ID/EX pipeline register.
- busy_o  out  1  at least one entry in flight.
- count_o  out  $clog2(DEPTH+1)  number of in-flight entries.

## Operation
- Circular table of DEPTH entries, each holding {id, state}. State is PENDING, COMMITTED or KILLED.
- Head pointer, tail pointer and count are all registered.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.

Issue:
- When issue_i and issue_ready_o are both high, write {issue_id_i, PENDING} at the tail, increment the tail pointer, and increment count.
- issue_i while issue_ready_o is low is ignored; no entry is written.

Commit:
- On commit_valid_i, compare commit_id_i against every valid entry.
- On a match, set that entry's state to COMMITTED, or to KILLED if commit_kill_i is set.
- If commit_id_i equals issue_id_i in the same cycle as an accepted issue, the new entry is written directly with the committed or killed state.
- A commit whose ID matches no entry is ignored.
- A second commit to an entry that is already COMMITTED or KILLED is ignored, so the first decision wins.
- The core guarantees that in-flight IDs are unique.

Head sequencing (combinational from registered head state):
- Head is PENDING: exec_valid_o = 0 and drop_o = 0.
- Head is COMMITTED: exec_valid_o = 1 and exec_id_o = head id. The entry pops on ex_done_i.
- Head is KILLED: drop_o = 1 and drop_id_o = head id. The entry pops unconditionally this cycle.
- exec_valid_o and drop_o are never high together.
- ex_done_i while exec_valid_o is low is ignored.

Count update: count_next = count + push - pop.

Flush and reset:
- clear_i invalidates all entries, resets head, tail and count to 0, and asserts clear_o the next cycle.
- clear_i takes priority over an issue, commit or pop in the same cycle.
- rst_i behaves like clear_i, except that clear_o stays 0.

## Timing
- Reset values: issue_ready_o = 1, and all other outputs = 0 (exec_valid_o, exec_id_o, drop_o, drop_id_o, clear_o, busy_o, count_o).
- issue_ready_o = (count != DEPTH). It is registered-state only and does not depend on a same-cycle pop, so there is no combinational path from ex_done_i.
- An issue at cycle N is visible in count_o, busy_o and the head at N+1.
- Earliest exec_valid_o for an entry is N+1, reached when the commit arrives in cycle N or earlier, including a commit in the same cycle as the issue.
- A commit at cycle M takes effect in head state at M+1.
- A pop at cycle P presents the next entry at P+1. This gives back-to-back retirement of 1 instruction/cycle.
- The table is full when count = DEPTH. issue_ready_o is low that cycle even if a pop also occurs; it rises the cycle after the pop.
- Simultaneous issue and pop at count = k gives count k at the next cycle.
- clear_i at cycle C gives count_o = 0 and clear_o = 1 at C+1. clear_o returns to 0 at C+2 unless clear_i is held.

## Test plan
- Basic issue/commit/execute:
  - Stimulus: issue ID 3 at cycle 0, commit ID 3 at cycle 2, ex_done_i at cycle 4.
  - Response: exec_valid_o = 1 with exec_id_o = 3 during cycles 3–4; count_o returns to 0 at cycle 5.
- Out-of-order commit, in-order release:
  - Stimulus: issue IDs 1, 2, 5; commit 5, then 2, then 1.
  - Response: exec_valid_o stays 0 until ID 1 commits; exec_id_o then sequences 1, 2, 5 on consecutive ex_done_i pulses.
- Kill:
  - Stimulus: issue IDs 4, 6; kill 4; commit 6.
  - Response: drop_o = 1 with drop_id_o = 4 for exactly one cycle; the next cycle exec_valid_o = 1 with exec_id_o = 6.
- Full table, DEPTH = 4:
  - Stimulus: issue 4 IDs with no commits, then drive issue_i for a fifth ID.
  - Response: issue_ready_o = 0, count_o = 4 and the fifth ID is not stored. After one commit and ex_done_i, issue_ready_o = 1 the following cycle.
  - Pointer wrap: 10 consecutive issue/commit/done cycles retire in order with no loss.
- Same-cycle commit and issue: issue ID 7 with commit_valid_i and commit_id_i = 7 in the same cycle gives exec_valid_o = 1 at the next cycle.
- Flush mid-operation:
  - Stimulus: 3 entries in flight, 1 of them committed; assert clear_i together with issue_i.
  - Response: next cycle count_o = 0, clear_o = 1, exec_valid_o = 0, and the issued ID is discarded.
  - Separately, asserting rst_i mid-operation gives the reset values with clear_o = 0.
